// File: rtl/four_function_calculator.sv
// ============================================================================
//  Module   : four_function_calculator
//  Purpose  : Button-driven four-function integer calculator. Operands arrive
//             in sign-magnitude, are converted to two's complement and are
//             combined with a W-bit accumulator. Multiply uses a sequential
//             shift-add on magnitudes; divide uses restoring division on
//             magnitudes. Out-of-range results raise a sticky Overflow flag.
//  Ports    : Clock     - system clock, rising edge
//             Clear     - synchronous active-high clear (C button)
//             Equals    - "=" button (level, edge-detected internally)
//             Add/Subtract/Multiply/Divide - operator buttons (level)
//             Number    - W-bit sign-magnitude operand
//             Result    - W-bit two's-complement accumulator (registered)
//             Overflow  - sticky error flag (registered)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module four_function_calculator #(
  parameter int W = 11
) (
  input  logic         Clock,
  input  logic         Clear,
  input  logic         Equals,
  input  logic         Add,
  input  logic         Subtract,
  input  logic         Multiply,
  input  logic         Divide,
  input  logic [W-1:0] Number,
  output logic [W-1:0] Result,
  output logic         Overflow
);

  typedef enum logic [2:0] {
    S_WAIT_FIRST  = 3'd0,
    S_WAIT_OP     = 3'd1,
    S_WAIT_SECOND = 3'd2,
    S_MUL_BUSY    = 3'd3,
    S_DIV_BUSY    = 3'd4,
    S_ERROR       = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  localparam int             c_CW       = $clog2(W);
  localparam int             c_PW       = 2 * W - 1;  // full |acc| * |operand| width
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(W - 1);
  localparam logic [W-1:0]   c_MIN      = {1'b1, {(W-1){1'b0}}};
  localparam logic [c_PW-1:0] c_POS_LIM = c_PW'(2**(W-1) - 1);
  localparam logic [c_PW-1:0] c_NEG_LIM = c_PW'(2**(W-1));

  state_t          r_state, w_state_nxt;
  op_t             r_op, w_op_sel;
  logic [W-1:0]    r_result;
  logic            r_ovf;
  logic [4:0]      r_btn, r_btn_d, w_press;
  logic [c_CW-1:0] r_cnt;
  logic            r_neg;

  // Multiplier datapath
  logic [c_PW-1:0] r_mcand, r_prod, w_prod_step;
  logic [W-2:0]    r_mplier;
  // Divider datapath: r_dvd shifts the dividend out and the quotient in
  logic [W-1:0]    r_dvd;
  logic [W-2:0]    r_rem, r_dvs, w_div_sub, w_rem_nxt;
  logic [W-1:0]    w_div_shift, w_quot;
  logic            w_qbit;

  logic [W-1:0]    w_num_ext, w_num_tc, w_acc_mag, w_mul_res, w_div_res, w_res_nxt;
  logic [W:0]      w_sum;
  logic            w_eq, w_any_op, w_as_ovf, w_div_bad, w_mul_ovf;
  logic            w_res_we, w_err_set, w_op_we, w_start;

  assign Result   = r_result;
  assign Overflow = r_ovf;

  // Buttons are level inputs; a press is a registered 0->1 transition.
  // The sync registers keep sampling during Clear so a button held through
  // Clear does not produce a fresh press afterwards.
  always_ff @(posedge Clock) begin
    r_btn   <= {Equals, Add, Subtract, Multiply, Divide};
    r_btn_d <= r_btn;
  end

  assign w_press  = r_btn & ~r_btn_d;
  assign w_eq     = w_press[4];
  assign w_any_op = |w_press[3:0];

  always_comb begin
    w_op_sel = OP_DIV;
    if      (w_press[3]) w_op_sel = OP_ADD;
    else if (w_press[2]) w_op_sel = OP_SUB;
    else if (w_press[1]) w_op_sel = OP_MUL;
  end

  // Sign-magnitude to two's complement; negative zero falls out as 0.
  assign w_num_ext = {1'b0, Number[W-2:0]};
  assign w_num_tc  = Number[W-1] ? (W'(0) - w_num_ext) : w_num_ext;
  assign w_acc_mag = r_result[W-1] ? (W'(0) - r_result) : r_result;

  // One extra bit exposes signed overflow of add/subtract.
  assign w_sum    = (r_op == OP_SUB) ? ({r_result[W-1], r_result} - {w_num_tc[W-1], w_num_tc})
                                     : ({r_result[W-1], r_result} + {w_num_tc[W-1], w_num_tc});
  assign w_as_ovf = w_sum[W] ^ w_sum[W-1];

  // Only quotients that cannot fit are caught up front; everything else fits.
  assign w_div_bad = (w_num_tc == '0) || ((r_result == c_MIN) && (w_num_tc == '1));

  assign w_prod_step = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
  assign w_mul_ovf   = r_prod > (r_neg ? c_NEG_LIM : c_POS_LIM);
  assign w_mul_res   = r_neg ? (W'(0) - r_prod[W-1:0]) : r_prod[W-1:0];

  // Restoring step. The remainder is always below the divisor, so the
  // subtraction is done in W-1 bits once the comparison has passed.
  assign w_div_shift = {r_rem, r_dvd[W-1]};
  assign w_qbit      = w_div_shift >= {1'b0, r_dvs};
  assign w_div_sub   = w_div_shift[W-2:0] - r_dvs;
  assign w_rem_nxt   = w_qbit ? w_div_sub : w_div_shift[W-2:0];
  assign w_quot      = {r_dvd[W-2:0], w_qbit};
  assign w_div_res   = r_neg ? (W'(0) - w_quot) : w_quot;

  always_ff @(posedge Clock) begin
    if (Clear) r_state <= S_WAIT_FIRST;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_res_we    = 1'b0;
    w_res_nxt   = r_result;
    w_err_set   = 1'b0;
    w_op_we     = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_WAIT_FIRST: begin
        if (w_eq) begin
          w_res_we    = 1'b1;
          w_res_nxt   = w_num_tc;
          w_state_nxt = S_WAIT_OP;
        end else if (w_any_op) begin
          w_res_we    = 1'b1;
          w_res_nxt   = '0;
          w_op_we     = 1'b1;
          w_state_nxt = S_WAIT_SECOND;
        end
      end
      S_WAIT_OP: begin
        // Equals here is deliberately a no-op.
        if (!w_eq && w_any_op) begin
          w_op_we     = 1'b1;
          w_state_nxt = S_WAIT_SECOND;
        end
      end
      S_WAIT_SECOND: begin
        if (w_eq) begin
          case (r_op)
            OP_MUL: begin
              w_start     = 1'b1;
              w_state_nxt = S_MUL_BUSY;
            end
            OP_DIV: begin
              if (w_div_bad) begin
                w_err_set   = 1'b1;
                w_state_nxt = S_ERROR;
              end else begin
                w_start     = 1'b1;
                w_state_nxt = S_DIV_BUSY;
              end
            end
            default: begin
              if (w_as_ovf) begin
                w_err_set   = 1'b1;
                w_state_nxt = S_ERROR;
              end else begin
                w_res_we    = 1'b1;
                w_res_nxt   = w_sum[W-1:0];
                w_state_nxt = S_WAIT_OP;
              end
            end
          endcase
        end else if (w_any_op) begin
          w_op_we = 1'b1;
        end
      end
      S_MUL_BUSY: begin
        // W-1 accumulate steps, then one edge to range-check and sign.
        if (r_cnt == c_CNT_LAST) begin
          if (w_mul_ovf) begin
            w_err_set   = 1'b1;
            w_state_nxt = S_ERROR;
          end else begin
            w_res_we    = 1'b1;
            w_res_nxt   = w_mul_res;
            w_state_nxt = S_WAIT_OP;
          end
        end
      end
      S_DIV_BUSY: begin
        // W steps (dividend magnitude may need W bits); the last step
        // writes the signed quotient directly.
        if (r_cnt == c_CNT_LAST) begin
          w_res_we    = 1'b1;
          w_res_nxt   = w_div_res;
          w_state_nxt = S_WAIT_OP;
        end
      end
      default: ;  // S_ERROR: only Clear leaves
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_op     <= OP_ADD;
      r_cnt    <= '0;
    end else begin
      if (w_res_we)  r_result <= w_res_nxt;
      if (w_err_set) r_ovf    <= 1'b1;
      if (w_op_we)   r_op     <= w_op_sel;
      if (w_start)
        r_cnt <= '0;
      else if (((r_state == S_MUL_BUSY) || (r_state == S_DIV_BUSY)) && (r_cnt != c_CNT_LAST))
        r_cnt <= r_cnt + c_CW'(1);
    end
  end

  // Operand datapath needs no reset: it is always loaded before use.
  always_ff @(posedge Clock) begin
    if (w_start) begin
      r_neg    <= r_result[W-1] ^ w_num_tc[W-1];
      r_mcand  <= c_PW'(w_acc_mag);
      r_mplier <= Number[W-2:0];
      r_prod   <= '0;
      r_dvd    <= w_acc_mag;
      r_dvs    <= Number[W-2:0];
      r_rem    <= '0;
    end else if (r_state == S_MUL_BUSY) begin
      if (r_cnt != c_CNT_LAST) begin
        r_prod   <= w_prod_step;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
    end else if (r_state == S_DIV_BUSY) begin
      r_rem <= w_rem_nxt;
      r_dvd <= w_quot;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_four_function_calculator.sv
// ============================================================================
//  Module   : tb_four_function_calculator
//  Purpose  : Self-checking bench for four_function_calculator. Expected
//             results are queued when the completing button is driven and
//             compared once the operation has had time to finish.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_four_function_calculator;

  localparam int W     = 11;
  localparam int B_EQ  = 0;
  localparam int B_ADD = 1;
  localparam int B_SUB = 2;
  localparam int B_MUL = 3;
  localparam int B_DIV = 4;

  logic         Clock  = 1'b0;
  logic         Clear  = 1'b1;
  logic [4:0]   r_btn  = '0;
  logic [W-1:0] Number = '0;
  logic [W-1:0] Result;
  logic         Overflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
  } exp_t;
  exp_t sb_q[$];

  four_function_calculator #(.W(W)) u_dut (
    .Clock    (Clock),
    .Clear    (Clear),
    .Equals   (r_btn[B_EQ]),
    .Add      (r_btn[B_ADD]),
    .Subtract (r_btn[B_SUB]),
    .Multiply (r_btn[B_MUL]),
    .Divide   (r_btn[B_DIV]),
    .Number   (Number),
    .Result   (Result),
    .Overflow (Overflow)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] to_sm(input int v);
    logic [W-1:0] r;
    if (v < 0) r = {1'b1, (W-1)'(-v)};
    else       r = W'(v);
    return r;
  endfunction

  function automatic int res_now();
    return int'($signed(Result));
  endfunction

  task automatic press(input int idx, input int hold);
    @(negedge Clock);
    r_btn[idx] = 1'b1;
    repeat (hold) @(negedge Clock);
    r_btn[idx] = 1'b0;
    repeat (W + 4) @(negedge Clock);
  endtask

  task automatic clear_dut();
    @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
  endtask

  task automatic sb_push(input int res, input logic ovf);
    exp_t e;
    e.res = res;
    e.ovf = ovf;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, ".queue"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".res"}, res_now(), int'($signed(e.res)));
      check({tag, ".ovf"}, int'(Overflow), int'(e.ovf));
    end
  endtask

  // Drive an operand, press Equals, and score the outcome.
  task automatic eq_expect(input string tag, input logic [W-1:0] num, input int res, input logic ovf);
    Number = num;
    sb_push(res, ovf);
    press(B_EQ, 1);
    sb_check(tag);
  endtask

  // Reference: integer arithmetic with the W-bit signed range check.
  task automatic model(input int a, input int op, input int b, output int r, output logic ovf);
    ovf = 1'b0;
    r   = 0;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      default: if (b == 0) ovf = 1'b1; else r = a / b;
    endcase
    if (r > (2**(W-1) - 1) || r < -(2**(W-1))) ovf = 1'b1;
    if (ovf) r = a;
  endtask

  initial begin
    int   a, b, opi, exp_r;
    logic exp_o;
    logic found;

    repeat (3) @(negedge Clock);
    Clear = 1'b0;
    check("reset.res", res_now(), 0);
    check("reset.ovf", int'(Overflow), 0);

    // First operand, then multiply with stretched button presses
    eq_expect("first_eq", to_sm(6), 6, 1'b0);
    press(B_MUL, 2);
    Number = to_sm(3);
    sb_push(18, 1'b0);
    @(negedge Clock);
    r_btn[B_EQ] = 1'b1;
    found = 1'b0;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge Clock);
      if (k == 2) r_btn[B_EQ] = 1'b0;
      if (res_now() == 18) begin
        found = 1'b1;
        break;
      end
    end
    r_btn[B_EQ] = 1'b0;
    check("mul_latency", int'(found), 1);
    repeat (W + 4) @(negedge Clock);
    sb_check("mul_once");

    // Subtract chain and repeated Equals
    clear_dut();
    eq_expect("sub_a", to_sm(5), 5, 1'b0);
    press(B_SUB, 1);
    eq_expect("sub_neg", to_sm(-9), 14, 1'b0);
    press(B_SUB, 1);
    eq_expect("sub_20", to_sm(20), -6, 1'b0);
    eq_expect("eq_repeat", to_sm(20), -6, 1'b0);

    // Divide, divide-by-zero, locked error state, clear
    clear_dut();
    eq_expect("div_a", to_sm(7), 7, 1'b0);
    press(B_DIV, 1);
    eq_expect("div_neg", 11'h402, -3, 1'b0);
    press(B_DIV, 1);
    eq_expect("div_zero", to_sm(0), -3, 1'b1);
    press(B_ADD, 1);
    eq_expect("err_locked", to_sm(5), -3, 1'b1);
    clear_dut();
    check("clr.res", res_now(), 0);
    check("clr.ovf", int'(Overflow), 0);

    // Overflow boundaries
    eq_expect("add_max", to_sm(1023), 1023, 1'b0);
    press(B_ADD, 1);
    eq_expect("add_ovf", to_sm(1), 1023, 1'b1);
    clear_dut();
    eq_expect("mul_a", to_sm(100), 100, 1'b0);
    press(B_MUL, 1);
    eq_expect("mul_ovf", to_sm(100), 100, 1'b1);

    // Clear aborts a multiply in progress
    clear_dut();
    eq_expect("abort_a", to_sm(50), 50, 1'b0);
    press(B_MUL, 1);
    Number = to_sm(20);
    @(negedge Clock);
    r_btn[B_EQ] = 1'b1;
    @(negedge Clock);
    r_btn[B_EQ] = 1'b0;
    repeat (3) @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
    check("abort.res", res_now(), 0);
    check("abort.ovf", int'(Overflow), 0);
    eq_expect("after_abort", to_sm(4), 4, 1'b0);

    // Negative zero and operator pressed first
    clear_dut();
    eq_expect("negzero", 11'h400, 0, 1'b0);
    clear_dut();
    eq_expect("nz_a", to_sm(5), 5, 1'b0);
    press(B_ADD, 1);
    eq_expect("nz_add", 11'h400, 5, 1'b0);
    clear_dut();
    press(B_SUB, 1);
    eq_expect("op_first", to_sm(7), -7, 1'b0);
    clear_dut();
    eq_expect("mn_a", to_sm(-32), -32, 1'b0);
    press(B_MUL, 1);
    eq_expect("mul_min", to_sm(32), -1024, 1'b0);

    // Random single operations against the integer model
    for (int i = 0; i < 10; i++) begin
      opi = $urandom_range(0, 3);
      a   = int'($urandom_range(0, 2046)) - 1023;
      if (opi == 2) b = int'($urandom_range(0, 40)) - 20;
      else          b = int'($urandom_range(0, 2046)) - 1023;
      model(a, opi, b, exp_r, exp_o);
      clear_dut();
      eq_expect("rand_a", to_sm(a), a, 1'b0);
      press(opi + 1, 1);
      eq_expect($sformatf("rand_%0d_op%0d", i, opi), to_sm(b), exp_r, exp_o);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
